div_monitor: RTL and testbench

Measures the divided clock produced by the divide-by-3 stage. Sits directly downstream of that stage's `final_out` and samples it in the `clk` domain. Reports, per cycle of the divided clock:
- period and high time, counted in `clk` cycles;
- a lock flag once the period matches the expected ratio for several consecutive cycles;
- error and timeout pulses.

---
 rtl/div_monitor.sv | 148 ++++++++++++++
 tb/tb_div_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_monitor.sv
// div_monitor: measures period and high time of a divided clock,
// tracks lock against an expected ratio, flags errors and timeouts.
module div_monitor #(
   parameter int CNT_W      = 8,
   parameter int EXP_PERIOD = 3,
   parameter int LOCK_CNT   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             err,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] EXP = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] SAT = '1;
   localparam logic [3:0]       LCK = 4'(LOCK_CNT);

   typedef enum logic {
      WAIT_EDGE = 1'b0,
      RUN       = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             s1;
   logic             s2;
   logic             s3;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] hi_lat;
   logic [3:0]       match_cnt;
   logic [3:0]       match_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic [CNT_W-1:0] high_nxt;
   logic             mv_nxt;
   logic             lock_nxt;
   logic             err_nxt;
   logic             to_nxt;

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   // two-flop synchronizer plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= div_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // rise-to-rise and high-time counters, high time captured on fall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
         hi_lat  <= '0;
      end else begin
         if (rise)
            per_cnt <= ONE;
         else if (per_cnt != SAT)
            per_cnt <= per_cnt + ONE;
         if (rise)
            hi_cnt <= ONE;
         else if (s2 && hi_cnt != SAT)
            hi_cnt <= hi_cnt + ONE;
         if (fall)
            hi_lat <= hi_cnt;
      end
   end

   // state and registered result/pulse outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= WAIT_EDGE;
         match_cnt  <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         match_cnt  <= match_nxt;
         period     <= period_nxt;
         high_time  <= high_nxt;
         meas_valid <= mv_nxt;
         locked     <= lock_nxt;
         err        <= err_nxt;
         timeout    <= to_nxt;
      end
   end

   // publish on rise once armed, run lock logic, detect a stalled input
   always_comb begin
      state_nxt  = state;
      match_nxt  = match_cnt;
      period_nxt = period;
      high_nxt   = high_time;
      mv_nxt     = 1'b0;
      lock_nxt   = locked;
      err_nxt    = 1'b0;
      to_nxt     = 1'b0;
      unique case (state)
         WAIT_EDGE: begin
            if (rise)
               state_nxt = RUN;
         end
         RUN: begin
            if (rise) begin
               period_nxt = per_cnt;
               high_nxt   = hi_lat;
               mv_nxt     = 1'b1;
               if (per_cnt == EXP) begin
                  if (match_cnt != LCK)
                     match_nxt = match_cnt + 4'd1;
                  if (match_nxt == LCK)
                     lock_nxt = 1'b1;
               end else begin
                  match_nxt = '0;
                  lock_nxt  = 1'b0;
                  err_nxt   = locked;
               end
            end else if (per_cnt == SAT) begin
               to_nxt    = 1'b1;
               lock_nxt  = 1'b0;
               match_nxt = '0;
               state_nxt = WAIT_EDGE;
            end
         end
         default: state_nxt = WAIT_EDGE;
      endcase
   end

endmodule

// File: tb/tb_div_monitor.sv
// tb_div_monitor: scoreboard bench for div_monitor, reference model
// works on run lengths of the sampled input waveform.
module tb_div_monitor;

   localparam int EXP  = 3;
   localparam int LCKN = 4;
   localparam int SATV = 255;

   typedef struct {
      int       due;
      bit       is_to;
      int       per;
      int       hi;
      bit       err;
      bit       lk;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       div_in;
   logic [7:0] period;
   logic [7:0] high_time;
   logic       meas_valid;
   logic       locked;
   logic       err;
   logic       timeout;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q[$];

   int   m_prev, m_run, m_match, m_lk, m_hrun, m_hlat, m_last;
   bit   m_exp_lk = 0;

   div_monitor #(.CNT_W(8), .EXP_PERIOD(EXP), .LOCK_CNT(LCKN)) dut (
      .clk       (clk),
      .rst       (rst),
      .div_in    (div_in),
      .period    (period),
      .high_time (high_time),
      .meas_valid(meas_valid),
      .locked    (locked),
      .err       (err),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d, required %0d",
                  nm, cyc, act, req);
      end
   endtask

   // reference model: rise events, run lengths, lock rules
   always @(posedge clk) begin
      exp_t e;
      int   d;
      int   cur;
      cyc++;
      if (!rst) begin
         m_prev = 0; m_run = 0; m_match = 0; m_lk = 0;
         m_hrun = 0; m_hlat = 0; m_last = 0;
      end else begin
         cur = int'(div_in);
         if (cur == 1 && m_prev == 0) begin
            if (m_run == 1) begin
               d       = cyc - m_last;
               e.due   = cyc + 2;
               e.is_to = 0;
               e.per   = (d > SATV) ? SATV : d;
               e.hi    = m_hlat;
               e.err   = 0;
               if (e.per == EXP) begin
                  m_match = (m_match + 1 > LCKN) ? LCKN : m_match + 1;
                  if (m_match == LCKN) m_lk = 1;
               end else begin
                  e.err   = (m_lk == 1);
                  m_match = 0;
                  m_lk    = 0;
               end
               e.lk = (m_lk == 1);
               q.push_back(e);
            end else begin
               m_run = 1;
            end
            m_last = cyc;
            m_hrun = 1;
         end else begin
            if (cur == 1) m_hrun++;
            if (cur == 0 && m_prev == 1)
               m_hlat = (m_hrun > SATV) ? SATV : m_hrun;
            if (m_run == 1 && cyc - m_last == SATV) begin
               e.due   = cyc + 2;
               e.is_to = 1;
               e.per   = 0;
               e.hi    = 0;
               e.err   = 0;
               e.lk    = 0;
               m_lk    = 0;
               m_match = 0;
               m_run   = 0;
               q.push_back(e);
            end
         end
         m_prev = cur;
      end
   end

   always @(negedge rst) q.delete();

   // monitor: pop and compare whenever the DUT presents an event
   always @(posedge clk) begin
      exp_t e;
      bit   ok;
      #1;
      if (!rst) begin
         m_exp_lk = 0;
      end else begin
         while (q.size() > 0 && q[0].due < cyc) begin
            chk("missing_event_cycle", cyc, q[0].due);
            m_exp_lk = q[0].lk;
            void'(q.pop_front());
         end
         if (meas_valid || timeout) begin
            ok = (q.size() > 0) && (q[0].due == cyc);
            chk("event_expected", ok, 1);
            if (ok) begin
               e = q.pop_front();
               chk("timeout", timeout, e.is_to);
               chk("meas_valid", meas_valid, !e.is_to);
               if (!e.is_to) begin
                  chk("period", period, e.per);
                  chk("high_time", high_time, e.hi);
                  chk("err", err, e.err);
               end
               chk("locked_evt", locked, e.lk);
               m_exp_lk = e.lk;
            end
         end else begin
            chk("locked_hold", locked, m_exp_lk);
            chk("err_idle", err, 0);
         end
      end
   end

   task automatic pat(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         repeat (hi) begin
            @(negedge clk);
            div_in = 1'b1;
         end
         repeat (lo) begin
            @(negedge clk);
            div_in = 1'b0;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_high_time"}, high_time, 0);
      chk({tag, "_meas_valid"}, meas_valid, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_timeout"}, timeout, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b0;
      div_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         chk_zero("reset");
         @(negedge clk);
         div_in = ~div_in;
      end
      @(negedge clk);
      div_in = 1'b0;
      rst    = 1'b1;

      pat(2, 1, 10);
      pat(3, 2, 4);
      pat(2, 1, 8);

      repeat (300) begin
         @(negedge clk);
         div_in = 1'b1;
      end
      @(negedge clk);
      div_in = 1'b0;
      pat(2, 1, 6);

      @(negedge clk);
      div_in = 1'b1;
      @(posedge clk);
      #2;
      chk("pre_reset_period", period, 3);
      chk("pre_reset_locked", locked, 1);
      #1;
      rst = 1'b0;
      #1;
      chk_zero("async_reset");
      @(posedge clk);
      @(negedge clk);
      rst    = 1'b1;
      div_in = 1'b0;

      pat(1, 1, 20);

      for (int b = 0; b < 40; b++) begin
         pat(2, 1, $urandom_range(6, 1));
         pat($urandom_range(5, 1), $urandom_range(5, 1), 1);
      end

      pat(1, 254, 2);
      pat(1, 255, 2);
      pat(2, 1, 3);

      @(negedge clk);
      div_in = 1'b0;
      repeat (6) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
